// File: rtl/cpu_pkg.sv
// Shared constants and types for the operand-fetch stage and its register file.
package cpu_pkg;

  localparam int unsigned NREG = 16;
  localparam int unsigned AW   = 4;
  localparam int unsigned DW   = 32;
  localparam int unsigned OPW  = 6;

  typedef logic [AW-1:0] reg_idx_t;
  typedef logic [DW-1:0] word_t;

endpackage

// File: rtl/operand_fetch_scoreboard.sv
// Busy scoreboard: one pending-write bit per register. Lookups are masked by
// the writeback happening this cycle, because that value is bypassed instead.
module scoreboard #(
  parameter int unsigned NREG = cpu_pkg::NREG,
  parameter int unsigned AW   = cpu_pkg::AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set_en,
  input  logic [AW-1:0] set_idx,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_idx,
  input  logic [AW-1:0] src1_idx,
  input  logic [AW-1:0] src2_idx,
  input  logic [AW-1:0] dst_idx,
  output logic          src1_busy,
  output logic          src2_busy,
  output logic          dst_busy
);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_next;

  // Next busy vector: clear applied first so a same-index set wins.
  always_comb begin
    busy_next = busy;
    if (clr_en) busy_next[clr_idx] = 1'b0;
    if (set_en) busy_next[set_idx] = 1'b1;
  end

  // Busy vector register, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_next;
  end

  // Lookups ignore a register whose writeback lands this cycle.
  always_comb begin
    src1_busy = busy[src1_idx] && !(clr_en && (clr_idx == src1_idx));
    src2_busy = busy[src2_idx] && !(clr_en && (clr_idx == src2_idx));
    dst_busy  = busy[dst_idx]  && !(clr_en && (clr_idx == dst_idx));
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: drives register file reads, bypasses writeback data,
// stalls on RAW/WAW hazards and registers the operand bundle for execute.
module operand_fetch #(
  parameter int unsigned NREG = cpu_pkg::NREG,
  parameter int unsigned AW   = cpu_pkg::AW,
  parameter int unsigned DW   = cpu_pkg::DW,
  parameter int unsigned OPW  = cpu_pkg::OPW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [AW-1:0]  in_rs1,
  input  logic [AW-1:0]  in_rs2,
  input  logic           in_use1,
  input  logic           in_use2,
  input  logic [AW-1:0]  in_rd,
  input  logic           in_wen,
  input  logic [OPW-1:0] in_op,
  input  logic [DW-1:0]  in_imm,
  output logic [AW-1:0]  rf_raddr1,
  output logic [AW-1:0]  rf_raddr2,
  input  logic [DW-1:0]  rf_rdata1,
  input  logic [DW-1:0]  rf_rdata2,
  input  logic           wb_wen,
  input  logic [AW-1:0]  wb_waddr,
  input  logic [DW-1:0]  wb_wdata,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DW-1:0]  out_a,
  output logic [DW-1:0]  out_b,
  output logic [AW-1:0]  out_rd,
  output logic           out_wen,
  output logic [OPW-1:0] out_op,
  output logic [DW-1:0]  out_imm
);

  logic          src1_busy;
  logic          src2_busy;
  logic          dst_busy;
  logic          src_haz1;
  logic          src_haz2;
  logic          waw;
  logic          space;
  logic          fire;
  logic [DW-1:0] opnd_a;
  logic [DW-1:0] opnd_b;

  assign rf_raddr1 = in_rs1;
  assign rf_raddr2 = in_rs2;

  scoreboard #(
    .NREG (NREG),
    .AW   (AW)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_en    (fire && in_wen),
    .set_idx   (in_rd),
    .clr_en    (wb_wen),
    .clr_idx   (wb_waddr),
    .src1_idx  (in_rs1),
    .src2_idx  (in_rs2),
    .dst_idx   (in_rd),
    .src1_busy (src1_busy),
    .src2_busy (src2_busy),
    .dst_busy  (dst_busy)
  );

  // Bypass muxes, hazard detection and handshake.
  always_comb begin
    opnd_a   = (wb_wen && (wb_waddr == in_rs1)) ? wb_wdata : rf_rdata1;
    opnd_b   = (wb_wen && (wb_waddr == in_rs2)) ? wb_wdata : rf_rdata2;
    src_haz1 = in_use1 && src1_busy;
    src_haz2 = in_use2 && src2_busy;
    waw      = in_wen && dst_busy;
    space    = !out_valid || out_ready;
    in_ready = space && !src_haz1 && !src_haz2 && !waw;
    fire     = in_valid && in_ready;
  end

  // Output bundle register; data fields hold when the bundle drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_rd    <= '0;
      out_wen   <= 1'b0;
      out_op    <= '0;
      out_imm   <= '0;
    end else if (fire) begin
      out_valid <= 1'b1;
      out_a     <= opnd_a;
      out_b     <= opnd_b;
      out_rd    <= in_rd;
      out_wen   <= in_wen;
      out_op    <= in_op;
      out_imm   <= in_imm;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios with literal
// expectations, then randomized traffic checked against a behavioural model.
module tb_operand_fetch;

  localparam int unsigned NREG = 16;
  localparam int unsigned AW   = 4;
  localparam int unsigned DW   = 32;
  localparam int unsigned OPW  = 6;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid, in_ready, in_use1, in_use2, in_wen;
  logic [AW-1:0]  in_rs1, in_rs2, in_rd;
  logic [OPW-1:0] in_op;
  logic [DW-1:0]  in_imm;
  logic [AW-1:0]  rf_raddr1, rf_raddr2;
  logic [DW-1:0]  rf_rdata1, rf_rdata2;
  logic           wb_wen;
  logic [AW-1:0]  wb_waddr;
  logic [DW-1:0]  wb_wdata;
  logic           out_valid, out_ready, out_wen;
  logic [DW-1:0]  out_a, out_b, out_imm;
  logic [AW-1:0]  out_rd;
  logic [OPW-1:0] out_op;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [NREG-1:0] m_busy;
  logic            m_valid;
  logic [DW-1:0]   m_a, m_b, m_imm;
  logic [AW-1:0]   m_rd;
  logic            m_wen;
  logic [OPW-1:0]  m_op;

  // Bench-side register file: combinational read, write at the clock edge.
  logic [DW-1:0] rf_mem [NREG];
  assign rf_rdata1 = rf_mem[rf_raddr1];
  assign rf_rdata2 = rf_mem[rf_raddr2];

  function automatic logic [DW-1:0] init_word(input int unsigned i);
    case (i)
      3:       return 32'h11;
      5:       return 32'h22;
      default: return 32'hA000_0000 | i;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) rf_mem[i] <= init_word(i);
    end else if (wb_wen) begin
      rf_mem[wb_waddr] <= wb_wdata;
    end
  end

  always #5 clk = ~clk;

  operand_fetch #(
    .NREG (NREG),
    .AW   (AW),
    .DW   (DW),
    .OPW  (OPW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_use1   (in_use1),
    .in_use2   (in_use2),
    .in_rd     (in_rd),
    .in_wen    (in_wen),
    .in_op     (in_op),
    .in_imm    (in_imm),
    .rf_raddr1 (rf_raddr1),
    .rf_raddr2 (rf_raddr2),
    .rf_rdata1 (rf_rdata1),
    .rf_rdata2 (rf_rdata2),
    .wb_wen    (wb_wen),
    .wb_waddr  (wb_waddr),
    .wb_wdata  (wb_wdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_rd    (out_rd),
    .out_wen   (out_wen),
    .out_op    (out_op),
    .out_imm   (out_imm)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy  = '0;
    m_valid = 1'b0;
    m_a     = '0;
    m_b     = '0;
    m_rd    = '0;
    m_wen   = 1'b0;
    m_op    = '0;
    m_imm   = '0;
  endtask

  // Per-cycle compare against the model, then advance the model across the edge.
  task automatic compare_cycle();
    logic          hit1, hit2, hitd, haz, exp_ready, fire;
    logic [DW-1:0] ea, eb;
    if (rst) begin
      model_reset();
      return;
    end
    hit1 = wb_wen && (wb_waddr == in_rs1);
    hit2 = wb_wen && (wb_waddr == in_rs2);
    hitd = wb_wen && (wb_waddr == in_rd);
    ea   = hit1 ? wb_wdata : rf_mem[in_rs1];
    eb   = hit2 ? wb_wdata : rf_mem[in_rs2];
    haz  = (in_use1 && m_busy[in_rs1] && !hit1) ||
           (in_use2 && m_busy[in_rs2] && !hit2) ||
           (in_wen  && m_busy[in_rd]  && !hitd);
    exp_ready = (!m_valid || out_ready) && !haz;
    fire      = in_valid && exp_ready;

    check("rf_raddr1", 128'(rf_raddr1), 128'(in_rs1));
    check("rf_raddr2", 128'(rf_raddr2), 128'(in_rs2));
    check("in_ready", 128'(in_ready), 128'(exp_ready));
    check("bundle",
          128'({out_valid, out_a, out_b, out_rd, out_wen, out_op, out_imm}),
          128'({m_valid, m_a, m_b, m_rd, m_wen, m_op, m_imm}));

    if (wb_wen) m_busy[wb_waddr] = 1'b0;
    if (fire && in_wen) m_busy[in_rd] = 1'b1;
    if (fire) begin
      m_valid = 1'b1;
      m_a     = ea;
      m_b     = eb;
      m_rd    = in_rd;
      m_wen   = in_wen;
      m_op    = in_op;
      m_imm   = in_imm;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  // Compare at the falling edge, then return 1 time unit after the rising edge.
  task automatic tick();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                        input logic u1, input logic u2, input logic [AW-1:0] rd,
                        input logic wen, input logic [OPW-1:0] op, input logic [DW-1:0] imm);
    in_valid = v;
    in_rs1   = r1;
    in_rs2   = r2;
    in_use1  = u1;
    in_use2  = u2;
    in_rd    = rd;
    in_wen   = wen;
    in_op    = op;
    in_imm   = imm;
  endtask

  task automatic set_wb(input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wb_wen   = en;
    wb_waddr = a;
    wb_wdata = d;
  endtask

  initial begin
    int unsigned cand[$];
    model_reset();
    set_in(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, '0, '0);
    set_wb(1'b0, '0, '0);
    out_ready = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("reset_bundle",
          128'({out_valid, out_a, out_b, out_rd, out_wen, out_op, out_imm}), 128'(0));

    // Plain issue: operands straight from the register file.
    set_in(1'b1, 4'd3, 4'd5, 1'b1, 1'b1, 4'd0, 1'b0, 6'h01, 32'h0);
    #1 check("t1_ready", 128'(in_ready), 128'(1));
    tick();
    check("t1_valid", 128'(out_valid), 128'(1));
    check("t1_a", 128'(out_a), 128'(32'h11));
    check("t1_b", 128'(out_b), 128'(32'h22));

    // RAW stall on r7, released by a bypassed writeback; rs1==rs2.
    set_in(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd7, 1'b1, 6'h02, 32'h7);
    tick();
    set_in(1'b1, 4'd7, 4'd7, 1'b1, 1'b1, 4'd0, 1'b0, 6'h03, 32'h8);
    #1 check("t2_stall", 128'(in_ready), 128'(0));
    tick();
    set_wb(1'b1, 4'd7, 32'hDEAD);
    #1 check("t2_bypass_ready", 128'(in_ready), 128'(1));
    tick();
    set_wb(1'b0, '0, '0);
    check("t2_a", 128'(out_a), 128'(32'hDEAD));
    check("t2_b", 128'(out_b), 128'(32'hDEAD));
    #1 check("t2_busy_cleared", 128'(in_ready), 128'(1));
    tick();
    set_in(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, '0, '0);

    // rd==rs1 not busy issues; reissue rd=4 during its own writeback.
    set_in(1'b1, 4'd4, 4'd0, 1'b1, 1'b0, 4'd4, 1'b1, 6'h04, 32'h40);
    #1 check("t3_rd_eq_rs1", 128'(in_ready), 128'(1));
    tick();
    set_in(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd4, 1'b1, 6'h05, 32'h41);
    set_wb(1'b1, 4'd4, 32'h4444);
    #1 check("t3_no_stall", 128'(in_ready), 128'(1));
    tick();
    set_wb(1'b0, '0, '0);
    set_in(1'b1, 4'd4, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 6'h06, 32'h42);
    #1 check("t3_busy_kept", 128'(in_ready), 128'(0));
    set_in(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, '0, '0);
    set_wb(1'b1, 4'd4, 32'h5555);
    tick();
    set_wb(1'b0, '0, '0);

    // Backpressure: bundle held for 3 cycles, then drained with a same-cycle fire.
    set_in(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd0, 1'b0, 6'h07, 32'hABCD);
    tick();
    out_ready = 1'b0;
    set_in(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd0, 1'b0, 6'h08, 32'h1234);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t4_hold_ready", 128'(in_ready), 128'(0));
      check("t4_hold_valid", 128'(out_valid), 128'(1));
      check("t4_hold_imm", 128'(out_imm), 128'(32'hABCD));
      tick();
    end
    out_ready = 1'b1;
    #1 check("t4_release_ready", 128'(in_ready), 128'(1));
    tick();
    check("t4_next_valid", 128'(out_valid), 128'(1));
    check("t4_next_imm", 128'(out_imm), 128'(32'h1234));
    set_in(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, '0, '0);
    tick();

    // WAW on r2 stalls until r2 is written back.
    set_in(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd2, 1'b1, 6'h09, 32'h20);
    tick();
    for (int k = 0; k < 2; k++) begin
      #1 check("t5_waw_stall", 128'(in_ready), 128'(0));
      tick();
    end
    set_wb(1'b1, 4'd2, 32'h2222);
    #1 check("t5_waw_release", 128'(in_ready), 128'(1));
    tick();
    set_in(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, '0, '0);
    set_wb(1'b1, 4'd2, 32'h2323);
    tick();
    set_wb(1'b0, '0, '0);

    // Asynchronous reset in the middle of a stall.
    set_in(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd9, 1'b1, 6'h0A, 32'h90);
    tick();
    out_ready = 1'b0;
    set_in(1'b1, 4'd9, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 6'h0B, 32'h91);
    tick();
    #1 check("t6_stalled", 128'(in_ready), 128'(0));
    #1 rst = 1'b1;
    #1;
    check("t6_async_valid", 128'(out_valid), 128'(0));
    check("t6_async_busy", 128'(in_ready), 128'(1));
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    set_in(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, '0, '0);
    tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      set_in(1'(($urandom % 10) < 7), AW'($urandom), AW'($urandom), 1'($urandom),
             1'($urandom), AW'($urandom), 1'($urandom), OPW'($urandom), $urandom);
      out_ready = (($urandom % 4) != 0);
      cand.delete();
      for (int unsigned i = 0; i < NREG; i++) if (m_busy[i]) cand.push_back(i);
      if ((cand.size() > 0) && (($urandom % 2) == 0))
        set_wb(1'b1, AW'(cand[$urandom % cand.size()]), $urandom);
      else if (($urandom % 10) == 0)
        set_wb(1'b1, AW'($urandom), $urandom);
      else
        set_wb(1'b0, '0, '0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
